// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller: FSM states,
// opcodes, datapath select codes and ALU operation codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU operation decoder: maps the controller's alu_op plus funct fields to an ALU code.
module alu_dec
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // funct7 only selects sub for register-register ops; addi ignores it
          3'b000:         alu_control = (op5 && funct7) ? ALU_SUB : ALU_ADD;
          3'b001:         alu_control = ALU_SLL;
          3'b010, 3'b011: alu_control = ALU_SLT;
          3'b100:         alu_control = ALU_XOR;
          3'b101:         alu_control = ALU_SRL;
          3'b110:         alu_control = ALU_OR;
          default:        alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing FSM: steps each instruction from fetch to writeback and
// drives datapath selects, write strobes and the memory req/ready handshake.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter bit WAIT_MEM        = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr
);

  // state    | meaning
  // FETCH    | read instr at PC, PC <= PC+4 on mem_ready
  // DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
  // MEMADR   | ALUOut <= rs1+imm
  // MEMREAD  | load data read at ALUOut
  // MEMWB    | rd <= load data
  // MEMWRITE | store to ALUOut
  // EXECR    | ALUOut <= rs1 op rs2
  // EXECI    | ALUOut <= rs1 op imm
  // ALUWB    | rd <= ALUOut
  // BRANCH   | compare rs1-rs2, PC <= ALUOut when taken
  // JAL      | PC <= target, ALUOut <= OldPC+4
  // TRAP     | parked on illegal instruction until reset

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       ready;
  logic       br_legal;
  logic       br_take;

  assign ready    = mem_ready | ~WAIT_MEM;
  assign br_legal = (funct3[2:1] == 2'b00);
  assign br_take  = (funct3 == 3'b000) ? zero : ~zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    alu_op        = ALUOP_ADD;
    imm_src       = imm_sel(opcode);

    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default: begin
            illegal_instr = 1'b1;
            state_d       = TRAP_ON_ILLEGAL ? TRAP : FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (ready) state_d = FETCH;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        if (br_legal) begin
          pc_write = br_take;
          state_d  = FETCH;
        end else begin
          illegal_instr = 1'b1;
          state_d       = TRAP_ON_ILLEGAL ? TRAP : FETCH;
        end
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      TRAP: begin
        illegal_instr = 1'b1;
        state_d       = TRAP;
      end
      default: state_d = FETCH;
    endcase

    // Reset kills outputs in the same cycle so an in-flight access cannot complete
    if (!rst_n) begin
      state_d       = FETCH;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      result_src    = RES_ALUOUT;
      alu_op        = ALUOP_ADD;
      imm_src       = IMM_I;
    end
  end

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .op5         (opcode[5]),
    .alu_control (alu_control)
  );

endmodule
